// File: rtl/data_mem_lsu.sv
// Byte-addressed RV32 data memory with a load/store front end.
// Two-stage pipeline: array access on accept, extension and response one edge later.
module data_mem_lsu #(
    parameter int unsigned DEPTH          = 1024,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [AW-1:0] clr_ptr;
    logic [31:0]   mem [DEPTH];

    logic          acc_c;
    logic [AW-1:0] widx_c;
    logic [1:0]    lane_c;
    logic          range_err_c;
    logic          funct3_ok_c;
    logic          align_err_c;
    logic          err_c;
    logic          wr_c;
    logic [3:0]    be_c;
    logic [31:0]   wdata_sh_c;

    logic          p_valid;
    logic          p_err;
    logic          p_load;
    logic [2:0]    p_funct3;
    logic [1:0]    p_lane;
    logic [31:0]   p_word;
    logic [31:0]   ld_sh_c;
    logic [31:0]   ld_data_c;

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state: leave CLEAR after the last word has been zeroed
    always_comb begin
        state_nx = state;
        case (state)
            ST_CLEAR: if (clr_ptr == AW'(DEPTH - 1)) state_nx = ST_IDLE;
            ST_IDLE:  state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            clr_ptr <= '0;
        end else if (state == ST_CLEAR) begin
            clr_ptr <= clr_ptr + AW'(1);
        end
    end

    assign req_ready = reset & (state == ST_IDLE);
    assign busy      = (state == ST_CLEAR);

    // Request decode and error classification
    always_comb begin
        acc_c       = req_valid & req_ready;
        widx_c      = req_addr[AW+1:2];
        lane_c      = req_addr[1:0];
        range_err_c = |(req_addr >> (AW + 2));

        funct3_ok_c = 1'b0;
        case (req_funct3)
            3'b000, 3'b001, 3'b010: funct3_ok_c = 1'b1;
            3'b100, 3'b101:         funct3_ok_c = ~req_we;
            default:                funct3_ok_c = 1'b0;
        endcase

        align_err_c = 1'b0;
        case (req_funct3[1:0])
            2'b01:   align_err_c = req_addr[0];
            2'b10:   align_err_c = |req_addr[1:0];
            default: align_err_c = 1'b0;
        endcase

        err_c = ~funct3_ok_c | align_err_c | range_err_c;
        wr_c  = acc_c & req_we & ~err_c;

        be_c = 4'b1111;
        case (req_funct3[1:0])
            2'b00:   be_c = 4'b0001 << lane_c;
            2'b01:   be_c = 4'b0011 << lane_c;
            default: be_c = 4'b1111;
        endcase

        wdata_sh_c = req_wdata << {lane_c, 3'b000};
    end

    // Word array: clear walk, byte-lane stores, registered read on accept
    always_ff @(posedge clk) begin
        if (reset) begin
            if (state == ST_CLEAR) begin
                mem[clr_ptr] <= '0;
            end else if (wr_c) begin
                for (int i = 0; i < 4; i++) begin
                    if (be_c[i]) mem[widx_c][8*i +: 8] <= wdata_sh_c[8*i +: 8];
                end
            end
        end
        if (acc_c) p_word <= mem[widx_c];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            p_valid  <= 1'b0;
            p_err    <= 1'b0;
            p_load   <= 1'b0;
            p_funct3 <= '0;
            p_lane   <= '0;
        end else begin
            p_valid <= acc_c;
            if (acc_c) begin
                p_err    <= err_c;
                p_load   <= ~req_we;
                p_funct3 <= req_funct3;
                p_lane   <= lane_c;
            end
        end
    end

    // Lane select and sign/zero extension
    always_comb begin
        ld_sh_c   = p_word >> {p_lane, 3'b000};
        ld_data_c = ld_sh_c;
        case (p_funct3)
            3'b000:  ld_data_c = {{24{ld_sh_c[7]}}, ld_sh_c[7:0]};
            3'b001:  ld_data_c = {{16{ld_sh_c[15]}}, ld_sh_c[15:0]};
            3'b100:  ld_data_c = {24'h0, ld_sh_c[7:0]};
            3'b101:  ld_data_c = {16'h0, ld_sh_c[15:0]};
            default: ld_data_c = ld_sh_c;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
        end else begin
            resp_valid <= p_valid;
            resp_err   <= p_valid & p_err;
            resp_rdata <= (p_valid & p_load & ~p_err) ? ld_data_c : 32'h0;
        end
    end

endmodule

// File: tb/tb_data_mem_lsu.sv
// Randomized bench for data_mem_lsu against a byte-array reference model.
module tb_data_mem_lsu;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned BYTES = 4 * DEPTH;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        busy;

    data_mem_lsu #(.DEPTH(DEPTH), .CLEAR_ON_RESET(1'b1)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .busy       (busy)
    );

    typedef struct {
        int unsigned due;
        logic        err;
        logic [31:0] rd;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  mem_m [BYTES];
    int          n_cmp;
    int          n_bad;
    int unsigned cyc;
    bit          mon_en;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference model: byte-level memory, spec rules in plain arithmetic
    task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, output logic err, output logic [31:0] rd);
        int unsigned n;
        logic        legal;
        logic [31:0] val;
        n     = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        legal = we ? (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2)
                   : (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        err = !legal || (addr % n != 0) || (addr >= BYTES);
        rd  = 32'h0;
        if (!err) begin
            if (we) begin
                for (int i = 0; i < int'(n); i++) mem_m[addr + i] = 8'((wd >> (8 * i)) & 32'hFF);
            end else begin
                val = 32'h0;
                for (int i = 0; i < int'(n); i++) val = val | (32'(mem_m[addr + i]) << (8 * i));
                if (n < 4 && !f3[2] && val[8*n-1]) val = val | ~((32'h1 << (8 * n)) - 1);
                rd = val;
            end
        end
    endtask

    // Issue one request; expectation from the model, or an explicit override
    task automatic issue_x(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, input bit use_x,
                           input logic x_err, input logic [31:0] x_rd);
        exp_t e;
        logic m_err;
        logic [31:0] m_rd;
        check("req_ready", 32'(req_ready), 32'h1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        model(we, f3, addr, wd, m_err, m_rd);
        e.due = cyc + 2;
        e.err = use_x ? x_err : m_err;
        e.rd  = use_x ? x_rd : m_rd;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd);
        issue_x(we, f3, addr, wd, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        idle(4);
        check("drain_queue", 32'(exp_q.size()), 32'h0);
        exp_q.delete();
    endtask

    // Reset for one edge, optionally re-reset after `cut` clear cycles, then time busy
    task automatic reset_and_clear(input int cut);
        int n;
        mon_en = 1'b0;
        reset  = 1'b0;
        @(posedge clk);
        #1;
        check("rst_ready", 32'(req_ready), 32'h0);
        check("rst_valid", 32'(resp_valid), 32'h0);
        check("rst_rdata", resp_rdata, 32'h0);
        check("rst_err", 32'(resp_err), 32'h0);
        reset = 1'b1;
        if (cut > 0) begin
            idle(cut);
            check("mid_clear_busy", 32'(busy), 32'h1);
            reset = 1'b0;
            @(posedge clk);
            #1;
            reset = 1'b1;
        end
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(posedge clk);
            #1;
        end
        check("busy_cycles", 32'(n), 32'(DEPTH));
        check("ready_after_clear", 32'(req_ready), 32'h1);
        check("busy_after_clear", 32'(busy), 32'h0);
        for (int i = 0; i < int'(BYTES); i++) mem_m[i] = 8'h0;
        mon_en = 1'b1;
    endtask

    // Response checker: one pulse exactly at the due cycle, zeros otherwise
    always @(negedge clk) begin
        if (mon_en) begin
            while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
                n_cmp++;
                n_bad++;
                $display("FAIL resp_missing: got none expected response due cycle %0d", exp_q[0].due);
                void'(exp_q.pop_front());
            end
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                check("resp_valid", 32'(resp_valid), 32'h1);
                check("resp_rdata", resp_rdata, exp_q[0].rd);
                check("resp_err", 32'(resp_err), 32'(exp_q[0].err));
                void'(exp_q.pop_front());
            end else begin
                check("idle_valid", 32'(resp_valid), 32'h0);
                check("idle_rdata", resp_rdata, 32'h0);
                check("idle_err", 32'(resp_err), 32'h0);
            end
        end
    end

    initial begin
        logic [31:0] a;
        logic [2:0]  f;
        n_cmp      = 0;
        n_bad      = 0;
        cyc        = 0;
        mon_en     = 1'b0;
        reset      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'h0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;

        reset_and_clear(0);

        for (int w = 0; w < int'(DEPTH); w++) issue_x(1'b0, 3'd2, 32'(4 * w), 32'h0, 1'b1, 1'b0, 32'h0);
        drain();

        issue_x(1'b1, 3'd2, 32'h8, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0);
        issue_x(1'b0, 3'd2, 32'h8, 32'h0, 1'b1, 1'b0, 32'hDEADBEEF);
        issue_x(1'b1, 3'd0, 32'h9, 32'h0000007F, 1'b1, 1'b0, 32'h0);
        issue_x(1'b0, 3'd2, 32'h8, 32'h0, 1'b1, 1'b0, 32'hDEAD7FEF);
        issue_x(1'b0, 3'd0, 32'hB, 32'h0, 1'b1, 1'b0, 32'hFFFFFFDE);
        issue_x(1'b0, 3'd4, 32'hB, 32'h0, 1'b1, 1'b0, 32'h000000DE);
        issue_x(1'b0, 3'd1, 32'hA, 32'h0, 1'b1, 1'b0, 32'hFFFFDEAD);
        issue_x(1'b1, 3'd2, 32'h6, 32'h12345678, 1'b1, 1'b1, 32'h0);
        issue_x(1'b0, 3'd2, 32'h4, 32'h0, 1'b1, 1'b0, 32'h0);
        issue_x(1'b0, 3'd1, 32'h3, 32'h0, 1'b1, 1'b1, 32'h0);
        issue_x(1'b0, 3'd5, 32'h2, 32'h0, 1'b1, 1'b0, 32'h0);
        issue_x(1'b0, 3'd2, 32'h40, 32'h0, 1'b1, 1'b1, 32'h0);
        issue_x(1'b1, 3'd4, 32'h8, 32'h11223344, 1'b1, 1'b1, 32'h0);
        issue_x(1'b0, 3'd2, 32'h8, 32'h0, 1'b1, 1'b0, 32'hDEAD7FEF);
        issue_x(1'b1, 3'd2, 32'h48, 32'hCAFEF00D, 1'b1, 1'b1, 32'h0);
        issue_x(1'b0, 3'd2, 32'h8, 32'h0, 1'b1, 1'b0, 32'hDEAD7FEF);
        drain();

        for (int k = 0; k < 500; k++) begin
            if ($urandom_range(0, 4) == 0) begin
                idle(1);
            end else begin
                f = 3'($urandom_range(0, 7));
                case ($urandom_range(0, 9))
                    0:       a = $urandom;
                    1:       a = 32'($urandom_range(BYTES, BYTES + 8));
                    default: a = 32'($urandom_range(0, BYTES - 1));
                endcase
                if ($urandom_range(0, 1) == 1) a = a & ~32'(f[1] ? 3 : f[0] ? 1 : 0);
                issue(1'($urandom_range(0, 1)), f, a, $urandom);
            end
        end
        drain();

        reset_and_clear(5);

        issue(1'b1, 3'd2, 32'h10, 32'h01020304);
        issue(1'b0, 3'd2, 32'h10, 32'h0);
        issue(1'b0, 3'd1, 32'h12, 32'h0);
        issue(1'b0, 3'd2, 32'h3C, 32'h0);
        for (int w = 0; w < int'(DEPTH); w++) issue(1'b0, 3'd2, 32'(4 * w), 32'h0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
